vga_sync_gen: RTL and testbench
===============================

Name: vga_sync_gen

Overview:
VGA 640x480@60 Hz timing generator, the consumer side of the 100 MHz to 25 MHz pixel-rate path. It runs entirely on CLK100MHZ and derives an internal one-cycle pixel enable, so no derived clock is used. It produces hsync, vsync, video_on and the pixel coordinates for the downstream pixel renderer and the court/ball drawing logic.

Parameters:
PIX_DIV, 4, CLK100MHZ cycles per pixel; legal range is 2 or more.
H_VIS / H_FP / H_SYNC / H_BP, 640 / 16 / 96 / 48, horizontal segment lengths in pixels; H_TOTAL = 800.
V_VIS / V_FP / V_SYNC / V_BP, 480 / 10 / 2 / 33, vertical segment lengths in lines; V_TOTAL = 525.
SYNC_POL, 0, active level of hsync and vsync; 0 means active-low.

Ports:
CLK100MHZ  in  1  system clock, 100 MHz
reset_n  in  1  asynchronous, active-low reset
pix_tick  out  1  one-cycle pulse every PIX_DIV clocks (the pixel enable)
hsync  out  1  horizontal sync
vsync  out  1  vertical sync
video_on  out  1  high while inside the 640x480 visible area
x  out  10  current horizontal pixel count, 0..799
y  out  10  current line count, 0..524
line_start  out  1  one-cycle pulse when x returns to 0
frame_start  out  1  one-cycle pulse when x and y both return to 0

Behaviour:
- Clocking and reset:
  - One clock domain, CLK100MHZ. Reset is asynchronous and active-low on reset_n.
  - While reset_n is low, all outputs and state take their reset values:
    - prescaler = 0, pix_tick = 0, x = 0, y = 0.
    - hsync = vsync = ~SYNC_POL (inactive level).
    - video_on = 0, line_start = 0, frame_start = 0.
- Prescaler:
  - Counts 0..PIX_DIV-1 and wraps to 0.
  - pix_tick is registered: it is high during the cycle after the prescaler reaches PIX_DIV-1.
  - After reset_n is released, the first pix_tick is high on the cycle following the PIX_DIV-th rising edge. It then repeats every PIX_DIV cycles.
- Counter advance (only on a clock edge where pix_tick = 1):
  - x increments. When x = H_TOTAL-1, x wraps to 0 and y increments.
  - When y = V_TOTAL-1 on that wrap, y wraps to 0.
  - On clock edges where pix_tick = 0, all counters and outputs hold.
- Output decode:
  - Outputs are registered and updated on the same edge as x and y, so they are always consistent with the x and y currently presented. There are no glitches and no extra latency relative to x and y.
  - video_on = (x < H_VIS) and (y < V_VIS).
  - hsync is at its active level iff H_VIS+H_FP <= x < H_VIS+H_FP+H_SYNC, i.e. x in 656..751.
  - vsync is at its active level iff V_VIS+V_FP <= y < V_VIS+V_FP+V_SYNC, i.e. y in 490..491. vsync is a pure function of y; it does not depend on x.
- Pulses:
  - line_start is high for exactly one CLK100MHZ cycle, the cycle in which x first reads 0 after a wrap.
  - frame_start is high for exactly one cycle, the cycle in which (x,y) first reads (0,0) after a wrap; line_start is also high in that cycle.
  - Neither pulse is asserted for the reset state (0,0); the first frame_start occurs at the first frame wrap.
- Widths: x and y are 10 bits. H_TOTAL-1 = 799 and V_TOTAL-1 = 524 both fit; counters never exceed TOTAL-1.
- Mid-operation reset: asserting reset_n low at any point immediately forces the reset values, regardless of clock. The timing restarts from (0,0) with a fresh prescaler phase.

Decomposition:
- Package vga_timing_pkg holds:
  - H/V segment constants and the derived H_TOTAL, V_TOTAL, HS_START, HS_END, VS_START, VS_END.
  - Coordinate width X_W = Y_W = 10.
- Sub-module pixel_tick_gen (parameter PIX_DIV; ports CLK100MHZ, reset_n, pix_tick) contains the prescaler and is reusable by other blocks that need the pixel-rate enable.
- vga_sync_gen instantiates pixel_tick_gen and contains the x/y counters and the registered decode.

Test Plan:
- Reset then release: all outputs at their reset values (hsync = vsync = 1, video_on = 0, x = y = 0); first pix_tick on the 4th clock after release; pix_tick period is 4 clocks thereafter.
- Hold across pix_tick = 0: x, y, hsync, vsync and video_on are stable for all 4 cycles of each pixel.
- Run one line (800 ticks = 3200 clocks):
  - video_on = 1 for x = 0..639.
  - hsync = 0 for exactly 96 ticks, x = 656..751.
  - line_start pulses once at the wrap, and y steps from 0 to 1.
- Run one full frame:
  - vsync = 0 for exactly 2 lines (y = 490, 491).
  - frame_start pulses once at a period of 800*525*4 = 1,680,000 clocks.
  - video_on = 0 for all y >= 480.
- Boundary checks:
  - At (799, 524), the next tick gives (0, 0) with frame_start = 1 and line_start = 1.
  - At (639, 479), the next tick gives video_on = 0.
- Reset mid-frame at (700, 300): outputs go to reset values immediately; after release the next frame_start occurs 1,680,000 clocks later.

Source files
------------

// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg: 640x480@60 Hz segment lengths, derived sync boundaries and
// coordinate widths shared by the VGA timing blocks.
package vga_timing_pkg;
    localparam int H_VIS    = 640;
    localparam int H_FP     = 16;
    localparam int H_SYNC   = 96;
    localparam int H_BP     = 48;
    localparam int H_TOTAL  = H_VIS + H_FP + H_SYNC + H_BP;
    localparam int HS_START = H_VIS + H_FP;
    localparam int HS_END   = HS_START + H_SYNC;
    localparam int V_VIS    = 480;
    localparam int V_FP     = 10;
    localparam int V_SYNC   = 2;
    localparam int V_BP     = 33;
    localparam int V_TOTAL  = V_VIS + V_FP + V_SYNC + V_BP;
    localparam int VS_START = V_VIS + V_FP;
    localparam int VS_END   = VS_START + V_SYNC;
    localparam int X_W      = 10;
    localparam int Y_W      = 10;
    function automatic logic sync_level(input logic active, input logic pol);
        return active ? pol : ~pol;
    endfunction
endpackage

// File: rtl/pixel_tick_gen.sv
// pixel_tick_gen: divides CLK100MHZ into a registered one-cycle pixel-rate
// enable, high the cycle after the prescaler reaches PIX_DIV-1.
module pixel_tick_gen #(
    parameter int PIX_DIV = 4
) (
    input  logic CLK100MHZ,
    input  logic reset_n,
    output logic pix_tick
);
    localparam int CW = $clog2(PIX_DIV);
    localparam logic [CW-1:0] LAST = CW'(PIX_DIV - 1);
    logic [CW-1:0] cnt_q, cnt_d;
    logic          tick_q, tick_d;
    always_comb begin
        tick_d = cnt_q == LAST;
        cnt_d  = tick_d ? '0 : cnt_q + 1'b1;
    end
    always_ff @(posedge CLK100MHZ or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q  <= '0;
            tick_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            tick_q <= tick_d;
        end
    end
    assign pix_tick = tick_q;
endmodule

// File: rtl/vga_sync_gen.sv
// vga_sync_gen: VGA raster timing on CLK100MHZ with a pixel enable; all
// outputs are registered on the same edge as the x/y counters they describe.
module vga_sync_gen
    import vga_timing_pkg::*;
#(
    parameter int PIX_DIV  = 4,
    parameter int H_VIS    = vga_timing_pkg::H_VIS,
    parameter int H_FP     = vga_timing_pkg::H_FP,
    parameter int H_SYNC   = vga_timing_pkg::H_SYNC,
    parameter int H_BP     = vga_timing_pkg::H_BP,
    parameter int V_VIS    = vga_timing_pkg::V_VIS,
    parameter int V_FP     = vga_timing_pkg::V_FP,
    parameter int V_SYNC   = vga_timing_pkg::V_SYNC,
    parameter int V_BP     = vga_timing_pkg::V_BP,
    parameter bit SYNC_POL = 1'b0
) (
    input  logic                            CLK100MHZ,
    input  logic                            reset_n,
    output logic                            pix_tick,
    output logic                            hsync,
    output logic                            vsync,
    output logic                            video_on,
    output logic [vga_timing_pkg::X_W-1:0]  x,
    output logic [vga_timing_pkg::Y_W-1:0]  y,
    output logic                            line_start,
    output logic                            frame_start
);
    localparam logic [X_W-1:0] X_VIS  = X_W'(H_VIS);
    localparam logic [X_W-1:0] X_LAST = X_W'(H_VIS + H_FP + H_SYNC + H_BP - 1);
    localparam logic [X_W-1:0] HS_LO  = X_W'(H_VIS + H_FP);
    localparam logic [X_W-1:0] HS_HI  = X_W'(H_VIS + H_FP + H_SYNC);
    localparam logic [Y_W-1:0] Y_VIS  = Y_W'(V_VIS);
    localparam logic [Y_W-1:0] Y_LAST = Y_W'(V_VIS + V_FP + V_SYNC + V_BP - 1);
    localparam logic [Y_W-1:0] VS_LO  = Y_W'(V_VIS + V_FP);
    localparam logic [Y_W-1:0] VS_HI  = Y_W'(V_VIS + V_FP + V_SYNC);

    logic           tick;
    logic           x_wrap, y_wrap;
    logic [X_W-1:0] x_q, x_d;
    logic [Y_W-1:0] y_q, y_d;
    logic           hs_q, hs_d, vs_q, vs_d, von_q, von_d, ls_q, ls_d, fs_q, fs_d;

    pixel_tick_gen #(.PIX_DIV(PIX_DIV)) u_tick (
        .CLK100MHZ (CLK100MHZ),
        .reset_n   (reset_n),
        .pix_tick  (tick)
    );

    // Decode from the next coordinates so outputs always match the x/y shown.
    always_comb begin
        x_wrap = x_q == X_LAST;
        y_wrap = y_q == Y_LAST;
        x_d    = tick ? (x_wrap ? '0 : x_q + 1'b1) : x_q;
        y_d    = (tick && x_wrap) ? (y_wrap ? '0 : y_q + 1'b1) : y_q;
        von_d  = tick ? (x_d < X_VIS && y_d < Y_VIS) : von_q;
        hs_d   = tick ? sync_level(x_d >= HS_LO && x_d < HS_HI, SYNC_POL) : hs_q;
        vs_d   = tick ? sync_level(y_d >= VS_LO && y_d < VS_HI, SYNC_POL) : vs_q;
        ls_d   = tick && x_wrap;
        fs_d   = tick && x_wrap && y_wrap;
    end

    always_ff @(posedge CLK100MHZ or negedge reset_n) begin
        if (!reset_n) begin
            x_q   <= '0;
            y_q   <= '0;
            von_q <= 1'b0;
            hs_q  <= ~SYNC_POL;
            vs_q  <= ~SYNC_POL;
            ls_q  <= 1'b0;
            fs_q  <= 1'b0;
        end else begin
            x_q   <= x_d;
            y_q   <= y_d;
            von_q <= von_d;
            hs_q  <= hs_d;
            vs_q  <= vs_d;
            ls_q  <= ls_d;
            fs_q  <= fs_d;
        end
    end

    assign pix_tick    = tick;
    assign hsync       = hs_q;
    assign vsync       = vs_q;
    assign video_on    = von_q;
    assign x           = x_q;
    assign y           = y_q;
    assign line_start  = ls_q;
    assign frame_start = fs_q;
endmodule

// File: tb/tb_vga_sync_gen.sv
// tb_vga_sync_gen: full-size and shrunken-geometry instances under random
// asynchronous resets, scored against a closed-form raster model.
module tb_vga_sync_gen;
    typedef struct packed {
        logic       tick;
        logic       hs;
        logic       vs;
        logic       von;
        logic [9:0] x;
        logic [9:0] y;
        logic       ls;
        logic       fs;
    } obs_t;

    localparam int NCYC = 30000;

    logic clk = 1'b0;
    logic rst_a_n = 1'b0;
    logic rst_b_n = 1'b0;
    logic       tick_a, hs_a, vs_a, von_a, ls_a, fs_a;
    logic [9:0] x_a, y_a;
    logic       tick_b, hs_b, vs_b, von_b, ls_b, fs_b;
    logic [9:0] x_b, y_b;

    obs_t q_a[$];
    obs_t q_b[$];
    int   n_chk = 0;
    int   n_err = 0;
    bit   started = 0;

    always #5 clk = ~clk;

    vga_sync_gen dut_a (
        .CLK100MHZ(clk), .reset_n(rst_a_n), .pix_tick(tick_a), .hsync(hs_a),
        .vsync(vs_a), .video_on(von_a), .x(x_a), .y(y_a),
        .line_start(ls_a), .frame_start(fs_a)
    );

    vga_sync_gen #(
        .PIX_DIV(3), .H_VIS(12), .H_FP(3), .H_SYNC(4), .H_BP(5),
        .V_VIS(6), .V_FP(2), .V_SYNC(2), .V_BP(3), .SYNC_POL(1'b1)
    ) dut_b (
        .CLK100MHZ(clk), .reset_n(rst_b_n), .pix_tick(tick_b), .hsync(hs_b),
        .vsync(vs_b), .video_on(von_b), .x(x_b), .y(y_b),
        .line_start(ls_b), .frame_start(fs_b)
    );

    // k = rising edges since reset release; n = pixels advanced so far.
    function automatic obs_t model(int k, int pd, int hv, int hf, int hsw, int hb,
                                   int vv, int vf, int vsw, int vb, bit pol);
        obs_t o;
        int ht, vt, n, px, py;
        bit adv;
        ht = hv + hf + hsw + hb;
        vt = vv + vf + vsw + vb;
        o = '0;
        o.hs = ~pol;
        o.vs = ~pol;
        if (k == 0) return o;
        n   = (k - 1) / pd;
        adv = n > 0 && (k - 1) % pd == 0;
        px  = n % ht;
        py  = (n / ht) % vt;
        o.tick = (k % pd) == 0;
        o.x    = 10'(px);
        o.y    = 10'(py);
        o.von  = n > 0 && px < hv && py < vv;
        o.hs   = (px >= hv + hf && px < hv + hf + hsw) ? pol : ~pol;
        o.vs   = (py >= vv + vf && py < vv + vf + vsw) ? pol : ~pol;
        o.ls   = adv && px == 0;
        o.fs   = adv && px == 0 && py == 0;
        return o;
    endfunction

    task automatic check(input string tag, input obs_t act, input obs_t exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s @%0t: got tick=%b hs=%b vs=%b von=%b x=%0d y=%0d ls=%b fs=%b, required tick=%b hs=%b vs=%b von=%b x=%0d y=%0d ls=%b fs=%b",
                     tag, $time, act.tick, act.hs, act.vs, act.von, act.x, act.y, act.ls, act.fs,
                     exp.tick, exp.hs, exp.vs, exp.von, exp.x, exp.y, exp.ls, exp.fs);
        end
    endtask

    initial begin
        int ka = 0, kb = 0;
        int a_hit, a_len, b_next, b_until;
        a_hit   = $urandom_range(7000, 9000);
        a_len   = $urandom_range(1, 3);
        b_next  = $urandom_range(2000, 4000);
        b_until = 0;
        for (int c = 0; c < NCYC; c++) begin
            @(posedge clk);
            #1;
            ka = rst_a_n ? ka + 1 : 0;
            kb = rst_b_n ? kb + 1 : 0;
            #1;
            if (c == b_next) begin
                b_until = c + $urandom_range(1, 3);
                b_next  = b_until + $urandom_range(300, 4000);
            end
            rst_a_n = !(c < 3 || (c >= a_hit && c < a_hit + a_len));
            rst_b_n = !(c < 2 || c < b_until);
            q_a.push_back(model(rst_a_n ? ka : 0, 4, 640, 16, 96, 48, 480, 10, 2, 33, 1'b0));
            q_b.push_back(model(rst_b_n ? kb : 0, 3, 12, 3, 4, 5, 6, 2, 2, 3, 1'b1));
            started = 1;
        end
        @(negedge clk);
        #1;
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        forever begin
            @(negedge clk);
            if (started) begin
                if (q_a.size() == 0) begin
                    n_chk++;
                    n_err++;
                    $display("FAIL dut_a_queue @%0t: got empty scoreboard, required one entry", $time);
                end else begin
                    check("dut_a", {tick_a, hs_a, vs_a, von_a, x_a, y_a, ls_a, fs_a}, q_a.pop_front());
                end
                if (q_b.size() == 0) begin
                    n_chk++;
                    n_err++;
                    $display("FAIL dut_b_queue @%0t: got empty scoreboard, required one entry", $time);
                end else begin
                    check("dut_b", {tick_b, hs_b, vs_b, von_b, x_b, y_b, ls_b, fs_b}, q_b.pop_front());
                end
            end
        end
    end
endmodule
